// File: rtl/pe_ctx_sequencer.sv
// Per-PE context sequencer: replays contexts 0..ctx_last for iter_num iterations onto the PE inst port.
// Optional performance counters are compiled in when PE_CTX_PERF_EN is defined.
module pe_ctx_sequencer #(
    parameter int INST_W = 45,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int ITER_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [INST_W-1:0] cfg_wdata,
    input  logic [ADDR_W-1:0] ctx_last,
    input  logic [ITER_W-1:0] iter_num,
    input  logic              start,
    input  logic              stall,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
`ifdef PE_CTX_PERF_EN
    ,
    output logic [31:0]       perf_run_cycles,
    output logic [31:0]       perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [INST_W-1:0] inst_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ITER_W-1:0] iter_q;
    logic [ADDR_W-1:0] ctx_last_q;
    logic [ITER_W-1:0] iter_num_q;
    logic              busy_q;
    logic              done_q;

    logic [INST_W-1:0] mem_q [DEPTH];

    logic              at_last_d;
    logic              last_iter_d;
    logic [ADDR_W-1:0] pc_inc_d;
    logic [ITER_W-1:0] iter_num_eff_d;

    // NOTE: the context memory has no reset so it maps onto plain RAM and survives rst.
    always_ff @(posedge clk) begin
        if (cfg_we && state_q == S_IDLE) begin
            mem_q[cfg_addr] <= cfg_wdata;
        end
    end

    always_comb begin
        at_last_d      = (pc_q == ctx_last_q);
        last_iter_d    = (iter_q == iter_num_q - ITER_W'(1));
        pc_inc_d       = pc_q + ADDR_W'(1);
        iter_num_eff_d = (iter_num == '0) ? ITER_W'(1) : iter_num;
    end

    // NOTE: non-blocking assignments let the same-cycle memory write stay invisible to the start read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            inst_q     <= '0;
            pc_q       <= '0;
            iter_q     <= '0;
            ctx_last_q <= '0;
            iter_num_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ctx_last_q <= ctx_last;
                        iter_num_q <= iter_num_eff_d;
                        inst_q     <= mem_q[0];
                        pc_q       <= '0;
                        iter_q     <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (!at_last_d) begin
                            pc_q   <= pc_inc_d;
                            inst_q <= mem_q[pc_inc_d];
                        end else if (!last_iter_d) begin
                            pc_q   <= '0;
                            iter_q <= iter_q + ITER_W'(1);
                            inst_q <= mem_q[0];
                        end else begin
                            inst_q  <= '0;
                            pc_q    <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign inst = inst_q;
    assign pc   = pc_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef PE_CTX_PERF_EN
    logic [31:0] run_cnt_q;
    logic [31:0] stall_cnt_q;

    // Counters saturate and keep their final values until the next accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            run_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else if (state_q == S_RUN) begin
            if (run_cnt_q != 32'hFFFF_FFFF) begin
                run_cnt_q <= run_cnt_q + 32'd1;
            end
            if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_run_cycles   = run_cnt_q;
    assign perf_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Directed self-checking bench for pe_ctx_sequencer; perf counters are checked when PE_CTX_PERF_EN is defined.
module tb_pe_ctx_sequencer;

    localparam int INST_W = 45;
    localparam int ADDR_W = 4;
    localparam int ITER_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_we = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [INST_W-1:0] cfg_wdata = '0;
    logic [ADDR_W-1:0] ctx_last = '0;
    logic [ITER_W-1:0] iter_num = '0;
    logic              start = 1'b0;
    logic              stall = 1'b0;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;
`ifdef PE_CTX_PERF_EN
    logic [31:0]       perf_run_cycles;
    logic [31:0]       perf_stall_cycles;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pe_ctx_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .ctx_last  (ctx_last),
        .iter_num  (iter_num),
        .start     (start),
        .stall     (stall),
        .inst      (inst),
        .pc        (pc),
        .busy      (busy),
        .done      (done)
`ifdef PE_CTX_PERF_EN
        ,
        .perf_run_cycles   (perf_run_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [INST_W-1:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic launch(input logic [ADDR_W-1:0] last, input logic [ITER_W-1:0] n);
        ctx_last = last;
        iter_num = n;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if ({inst, pc, busy, done} !== {45'h0, 4'h0, 2'b00}) begin
            failures++;
            $display("FAIL reset_state: inst=%h pc=%0d busy=%b done=%b, want all zero", inst, pc, busy, done);
        end
        #3 rst = 1'b1;
        step();
        checks++;
        if ({inst, pc, busy, done} !== {45'h0, 4'h0, 2'b00}) begin
            failures++;
            $display("FAIL idle_after_reset: inst=%h pc=%0d busy=%b done=%b, want all zero", inst, pc, busy, done);
        end
    endtask

    task automatic test_basic();
        logic [INST_W-1:0] e_inst [6] = '{45'h1, 45'h2, 45'h3, 45'h1, 45'h2, 45'h3};
        logic [ADDR_W-1:0] e_pc   [6] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
        wr(4'd0, 45'h1);
        wr(4'd1, 45'h2);
        wr(4'd2, 45'h3);
        launch(4'd2, 16'd2);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({inst, pc, busy, done} !== {e_inst[i], e_pc[i], 2'b10}) begin
                failures++;
                $display("FAIL basic_seq[%0d]: inst=%h pc=%0d busy=%b done=%b, want inst=%h pc=%0d busy=1 done=0",
                         i, inst, pc, busy, done, e_inst[i], e_pc[i]);
            end
            step();
        end
        checks++;
        if ({inst, pc, busy, done} !== {45'h0, 4'h0, 2'b01}) begin
            failures++;
            $display("FAIL basic_done: inst=%h pc=%0d busy=%b done=%b, want inst=0 pc=0 busy=0 done=1", inst, pc, busy, done);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({inst, pc, busy, done} !== {45'h0, 4'h0, 2'b00}) begin
            failures++;
            $display("FAIL start_in_done_ignored: inst=%h pc=%0d busy=%b done=%b, want idle zeros", inst, pc, busy, done);
        end
    endtask

    task automatic test_stall();
        logic [INST_W-1:0] e_inst [9] = '{45'h1, 45'h2, 45'h2, 45'h2, 45'h2, 45'h3, 45'h1, 45'h2, 45'h3};
        logic [ADDR_W-1:0] e_pc   [9] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
        logic              stl    [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        launch(4'd2, 16'd2);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if ({inst, pc, busy, done} !== {e_inst[i], e_pc[i], 2'b10}) begin
                failures++;
                $display("FAIL stall_seq[%0d]: inst=%h pc=%0d busy=%b done=%b, want inst=%h pc=%0d busy=1 done=0",
                         i, inst, pc, busy, done, e_inst[i], e_pc[i]);
            end
            stall = stl[i];
            step();
        end
        checks++;
        if ({inst, pc, busy, done} !== {45'h0, 4'h0, 2'b01}) begin
            failures++;
            $display("FAIL stall_done: inst=%h pc=%0d busy=%b done=%b, want inst=0 pc=0 busy=0 done=1", inst, pc, busy, done);
        end
`ifdef PE_CTX_PERF_EN
        checks++;
        if ({perf_run_cycles, perf_stall_cycles} !== {32'd9, 32'd3}) begin
            failures++;
            $display("FAIL perf_counts: run=%0d stall=%0d, want run=9 stall=3", perf_run_cycles, perf_stall_cycles);
        end
`endif
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;
        checks++;
        if ({inst, pc, busy, done} !== {45'h0, 4'h0, 2'b00}) begin
            failures++;
            $display("FAIL stall_in_idle: inst=%h pc=%0d busy=%b done=%b, want idle zeros", inst, pc, busy, done);
        end
`ifdef PE_CTX_PERF_EN
        checks++;
        if ({perf_run_cycles, perf_stall_cycles} !== {32'd9, 32'd3}) begin
            failures++;
            $display("FAIL perf_hold: run=%0d stall=%0d, want run=9 stall=3", perf_run_cycles, perf_stall_cycles);
        end
`endif
    endtask

    task automatic test_cfg_during_run();
        logic [INST_W-1:0] e_inst [6] = '{45'h1, 45'h2, 45'h3, 45'h1, 45'h2, 45'h3};
        logic [ADDR_W-1:0] e_pc   [6] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
        launch(4'd2, 16'd2);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({inst, pc, busy, done} !== {e_inst[i], e_pc[i], 2'b10}) begin
                failures++;
                $display("FAIL cfg_in_run_seq[%0d]: inst=%h pc=%0d busy=%b done=%b, want inst=%h pc=%0d busy=1 done=0",
                         i, inst, pc, busy, done, e_inst[i], e_pc[i]);
            end
            cfg_we    = (i == 1);
            start     = (i == 1);
            cfg_addr  = 4'd1;
            cfg_wdata = 45'hABC;
            step();
        end
        cfg_we = 1'b0;
        start  = 1'b0;
        checks++;
        if ({inst, pc, busy, done} !== {45'h0, 4'h0, 2'b01}) begin
            failures++;
            $display("FAIL cfg_in_run_done: inst=%h pc=%0d busy=%b done=%b, want inst=0 pc=0 busy=0 done=1", inst, pc, busy, done);
        end
        step();
    endtask

    task automatic test_async_reset();
        logic [INST_W-1:0] e_inst [6] = '{45'h1, 45'h2, 45'h3, 45'h1, 45'h2, 45'h3};
        launch(4'd2, 16'd2);
        step();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({inst, pc, busy, done} !== {45'h0, 4'h0, 2'b00}) begin
            failures++;
            $display("FAIL async_reset_immediate: inst=%h pc=%0d busy=%b done=%b, want all zero", inst, pc, busy, done);
        end
        step();
        checks++;
        if ({inst, pc, busy, done} !== {45'h0, 4'h0, 2'b00}) begin
            failures++;
            $display("FAIL async_reset_held: inst=%h pc=%0d busy=%b done=%b, want all zero", inst, pc, busy, done);
        end
        #3 rst = 1'b1;
        step();
        launch(4'd2, 16'd2);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({inst, busy, done} !== {e_inst[i], 2'b10}) begin
                failures++;
                $display("FAIL replay_after_reset[%0d]: inst=%h busy=%b done=%b, want inst=%h busy=1 done=0",
                         i, inst, busy, done, e_inst[i]);
            end
            step();
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL replay_done: done=%b, want 1", done);
        end
        step();
    endtask

    task automatic test_write_with_start();
        cfg_we    = 1'b1;
        cfg_addr  = 4'd0;
        cfg_wdata = 45'h77;
        launch(4'd0, 16'd1);
        cfg_we = 1'b0;
        checks++;
        if ({inst, busy} !== {45'h1, 1'b1}) begin
            failures++;
            $display("FAIL write_start_old_value: inst=%h busy=%b, want inst=1 busy=1", inst, busy);
        end
        step();
        step();
        launch(4'd0, 16'd1);
        checks++;
        if ({inst, busy} !== {45'h77, 1'b1}) begin
            failures++;
            $display("FAIL write_start_new_value: inst=%h busy=%b, want inst=77 busy=1", inst, busy);
        end
        step();
        step();
    endtask

    task automatic test_ctx_last_zero();
        wr(4'd0, 45'h1F);
        launch(4'd0, 16'd0);
        checks++;
        if ({inst, pc, busy, done} !== {45'h1F, 4'h0, 2'b10}) begin
            failures++;
            $display("FAIL iter_zero_run: inst=%h pc=%0d busy=%b done=%b, want inst=1f pc=0 busy=1 done=0", inst, pc, busy, done);
        end
        step();
        checks++;
        if ({inst, busy, done} !== {45'h0, 2'b01}) begin
            failures++;
            $display("FAIL iter_zero_done: inst=%h busy=%b done=%b, want inst=0 busy=0 done=1", inst, busy, done);
        end
        step();
        launch(4'd0, 16'd3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({inst, pc, busy, done} !== {45'h1F, 4'h0, 2'b10}) begin
                failures++;
                $display("FAIL hold_single_ctx[%0d]: inst=%h pc=%0d busy=%b done=%b, want inst=1f pc=0 busy=1 done=0",
                         i, inst, pc, busy, done);
            end
            step();
        end
        checks++;
        if ({inst, busy, done} !== {45'h0, 2'b01}) begin
            failures++;
            $display("FAIL hold_single_done: inst=%h busy=%b done=%b, want inst=0 busy=0 done=1", inst, busy, done);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_cfg_during_run();
        test_async_reset();
        test_write_with_start();
        test_ctx_last_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
